// File: rtl/mux_n_stream_pkg.sv
// rtl/mux_n_stream_pkg.sv - shared constants and helpers for the N-to-1 stream mux
package mux_n_stream_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  // Round-robin distance of channel idx from the slot after last; 0 = highest priority.
  function automatic int rr_dist(input int idx, input int last, input int n);
    return (idx + 2 * n - last - 1) % n;
  endfunction

endpackage

// File: rtl/mux_n_stream_rr_arbiter.sv
// rtl/mux_n_stream_rr_arbiter.sv - combinational round-robin grant, searching from last+1 mod N
module mux_n_stream_rr_arbiter
  import mux_n_stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  input  logic             enable,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  always_comb begin
    int w_best_d;
    int w_d;
    w_best_d  = N;
    w_d       = 0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_d = rr_dist(i, int'(last), N);
        if (w_d < w_best_d) begin
          w_best_d  = w_d;
          grant_idx = SEL_W'(i);
        end
      end
    end
    grant_valid = enable && (w_best_d < N);
  end

endmodule

// File: rtl/mux_n_stream.sv
// rtl/mux_n_stream.sv - registered N-to-1 stream mux with external-select or round-robin grant
module mux_n_stream
  import mux_n_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N),
  parameter int MODE  = MODE_SELECT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_chan,
  input  logic                 out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_chan;
  logic [SEL_W-1:0] r_last;

  logic             w_slot;
  logic             w_arb_valid;
  logic [SEL_W-1:0] w_arb_idx;
  logic             w_sel_valid;
  logic             w_grant_valid;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_data;

  assign w_slot = !r_valid || out_ready;

  mux_n_stream_rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req         (in_valid),
    .last        (r_last),
    .enable      (MODE == MODE_RR),
    .grant_valid (w_arb_valid),
    .grant_idx   (w_arb_idx)
  );

  // Out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) w_sel_valid = 1'b1;
    end
  end

  assign w_grant_valid = (MODE == MODE_RR) ? w_arb_valid : w_sel_valid;
  assign w_grant_idx   = (MODE == MODE_RR) ? w_arb_idx   : sel;

  always_comb begin
    in_ready = '0;
    w_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_slot && w_grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_last  <= SEL_W'(N - 1);
    end else if (w_slot) begin
      if (w_grant_valid) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_chan  <= w_grant_idx;
        if (MODE == MODE_RR) r_last <= w_grant_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_mux_n_stream.sv
// tb/tb_mux_n_stream.sv - directed bench for mux_n_stream in four configurations
module tb_mux_n_stream;

  logic clk;
  logic rst_n;

  // a: N=4 round-robin
  logic [63:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_chan;
  logic [15:0] a_out_data;
  logic        a_out_valid, a_out_ready;
  // b: N=4 external select
  logic [63:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_chan;
  logic [15:0] b_out_data;
  logic        b_out_valid, b_out_ready;
  // c: N=3 round-robin
  logic [47:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_chan;
  logic [15:0] c_out_data;
  logic        c_out_valid, c_out_ready;
  // d: N=3 external select
  logic [47:0] d_in_data;
  logic [2:0]  d_in_valid, d_in_ready;
  logic [1:0]  d_sel, d_out_chan;
  logic [15:0] d_out_data;
  logic        d_out_valid, d_out_ready;

  int n_vec;
  int n_err;

  mux_n_stream #(.WIDTH(16), .N(4), .MODE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_chan(a_out_chan), .out_ready(a_out_ready));
  mux_n_stream #(.WIDTH(16), .N(4), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_chan(b_out_chan), .out_ready(b_out_ready));
  mux_n_stream #(.WIDTH(16), .N(3), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_chan(c_out_chan), .out_ready(c_out_ready));
  mux_n_stream #(.WIDTH(16), .N(3), .MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .sel(d_sel), .out_data(d_out_data),
    .out_valid(d_out_valid), .out_chan(d_out_chan), .out_ready(d_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_in_valid = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_valid = '0; b_sel = '0; b_out_ready = 1'b1;
    c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;
    d_in_valid = '0; d_sel = '0; d_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'h00A0 + 16'(i);
    b_in_data = {16'h3333, 16'hBEEF, 16'h2222, 16'h1111};
    for (int i = 0; i < 3; i++) c_in_data[i*16 +: 16] = 16'h00C0 + 16'(i);
    d_in_data = {16'hD002, 16'hD001, 16'hD000};

    tick(); tick(); tick();
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data",  32'(a_out_data),  32'd0);
    chk("rst_a_chan",  32'(a_out_chan),  32'd0);
    chk("rst_c_valid", 32'(c_out_valid), 32'd0);
    rst_n = 1'b1;

    // round-robin fairness, all valid, no bubbles
    a_in_valid = 4'hF;
    #1 chk("a_rdy_first", 32'(a_in_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("a_rr_chan",  32'(a_out_chan),  32'(k % 4));
      chk("a_rr_data",  32'(a_out_data),  32'h00A0 + 32'(k % 4));
      chk("a_rr_valid", 32'(a_out_valid), 32'd1);
      chk("a_rr_rdy",   32'(a_in_ready),  32'(1 << ((k + 1) % 4)));
    end

    // back-pressure: output holds channel 1 word for 5 cycles
    a_out_ready = 1'b0;
    #1 chk("a_bp_rdy0", 32'(a_in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("a_bp_data",  32'(a_out_data),  32'h00A1);
      chk("a_bp_chan",  32'(a_out_chan),  32'd1);
      chk("a_bp_valid", 32'(a_out_valid), 32'd1);
      chk("a_bp_rdy",   32'(a_in_ready),  32'd0);
    end
    a_out_ready = 1'b1;
    #1 chk("a_rel_rdy", 32'(a_in_ready), 32'b0100);
    tick();
    chk("a_rel_chan",  32'(a_out_chan),  32'd2);
    chk("a_rel_data",  32'(a_out_data),  32'h00A2);
    chk("a_rel_valid", 32'(a_out_valid), 32'd1);
    chk("a_rel_rdy2",  32'(a_in_ready),  32'b1000);
    tick();
    chk("a_last3_chan", 32'(a_out_chan), 32'd3);

    // sparse requests with last=3: 1, 3, 1
    a_in_valid = 4'b1010;
    #1 chk("a_sp_rdy0", 32'(a_in_ready), 32'b0010);
    tick();
    chk("a_sp_chan0", 32'(a_out_chan), 32'd1);
    chk("a_sp_data0", 32'(a_out_data), 32'h00A1);
    chk("a_sp_rdy1",  32'(a_in_ready), 32'b1000);
    tick();
    chk("a_sp_chan1", 32'(a_out_chan), 32'd3);
    chk("a_sp_data1", 32'(a_out_data), 32'h00A3);
    chk("a_sp_rdy2",  32'(a_in_ready), 32'b0010);
    tick();
    chk("a_sp_chan2", 32'(a_out_chan), 32'd1);

    // drain: no requests -> valid drops, data/chan hold
    a_in_valid = 4'h0;
    #1 chk("a_dr_rdy", 32'(a_in_ready), 32'd0);
    tick();
    chk("a_dr_valid", 32'(a_out_valid), 32'd0);
    chk("a_dr_data",  32'(a_out_data),  32'h00A1);
    chk("a_dr_chan",  32'(a_out_chan),  32'd1);

    // reset mid-stream
    a_in_valid = 4'hF;
    #1 chk("a_pre_rst_rdy", 32'(a_in_ready), 32'b0100);
    tick();
    chk("a_pre_rst_chan", 32'(a_out_chan), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("a_arst_valid", 32'(a_out_valid), 32'd0);
    chk("a_arst_data",  32'(a_out_data),  32'd0);
    chk("a_arst_chan",  32'(a_out_chan),  32'd0);
    rst_n = 1'b1;
    #1 chk("a_post_rst_rdy", 32'(a_in_ready), 32'b0001);
    tick();
    chk("a_post_rst_chan", 32'(a_out_chan), 32'd0);
    chk("a_post_rst_data", 32'(a_out_data), 32'h00A0);
    a_in_valid = 4'h0;

    // external select
    b_sel = 2'd2;
    b_in_valid = 4'b0100;
    #1 chk("b_rdy_sel2", 32'(b_in_ready), 32'b0100);
    tick();
    chk("b_data_sel2",  32'(b_out_data),  32'hBEEF);
    chk("b_chan_sel2",  32'(b_out_chan),  32'd2);
    chk("b_valid_sel2", 32'(b_out_valid), 32'd1);
    b_sel = 2'd1;
    #1 chk("b_rdy_nofb", 32'(b_in_ready), 32'd0);
    tick();
    chk("b_valid_nofb", 32'(b_out_valid), 32'd0);
    chk("b_data_nofb",  32'(b_out_data),  32'hBEEF);
    b_sel = 2'd0;
    b_in_valid = 4'b0001;
    tick();
    chk("b_chan_sel0", 32'(b_out_chan), 32'd0);
    b_out_ready = 1'b0;
    b_sel = 2'd3;
    b_in_valid = 4'b1000;
    #1 chk("b_stall_rdy", 32'(b_in_ready), 32'd0);
    tick();
    chk("b_stall_chan", 32'(b_out_chan), 32'd0);
    chk("b_stall_data", 32'(b_out_data), 32'h1111);
    b_out_ready = 1'b1;
    #1 chk("b_rel_rdy", 32'(b_in_ready), 32'b1000);
    tick();
    chk("b_rel_chan", 32'(b_out_chan), 32'd3);
    chk("b_rel_data", 32'(b_out_data), 32'h3333);

    // N=3 round-robin wrap
    c_in_valid = 3'b111;
    #1 chk("c_rdy_first", 32'(c_in_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("c_rr_chan", 32'(c_out_chan), 32'(k % 3));
      chk("c_rr_data", 32'(c_out_data), 32'h00C0 + 32'(k % 3));
      chk("c_rr_rdy",  32'(c_in_ready), 32'(1 << ((k + 1) % 3)));
    end

    // N=3 select out of range
    d_sel = 2'd3;
    d_in_valid = 3'b111;
    #1 chk("d_rdy_sel3", 32'(d_in_ready), 32'd0);
    tick();
    chk("d_valid_sel3", 32'(d_out_valid), 32'd0);
    d_sel = 2'd2;
    #1 chk("d_rdy_sel2", 32'(d_in_ready), 32'b100);
    tick();
    chk("d_chan_sel2", 32'(d_out_chan), 32'd2);
    chk("d_data_sel2", 32'(d_out_data), 32'hD002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
